// File: rtl/vx_ahb_mem_arbiter.sv
// Round-robin arbiter: NUM_REQS Vortex memory requesters share one AHB adapter port, one transaction outstanding.
// Optional response watchdog enabled by defining VX_AHB_ARB_TIMEOUT_EN (TIMEOUT_CYCLES sets the limit).
module vx_ahb_mem_arbiter #(
   parameter int NUM_REQS       = 2,
   parameter int DATA_WIDTH     = 512,
   parameter int ADDR_WIDTH     = 26,
   parameter int TAG_WIDTH      = 56,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                clk,
   input  logic                                reset,

   input  logic [NUM_REQS-1:0]                 up_req_valid,
   input  logic [NUM_REQS-1:0]                 up_req_rw,
   input  logic [NUM_REQS*(DATA_WIDTH/8)-1:0]  up_req_byteen,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0]      up_req_addr,
   input  logic [NUM_REQS*DATA_WIDTH-1:0]      up_req_data,
   input  logic [NUM_REQS*TAG_WIDTH-1:0]       up_req_tag,
   output logic [NUM_REQS-1:0]                 up_req_ready,

   output logic [NUM_REQS-1:0]                 up_rsp_valid,
   output logic [DATA_WIDTH-1:0]               up_rsp_data,
   output logic [TAG_WIDTH-1:0]                up_rsp_tag,
   output logic                                up_rsp_timeout,
   input  logic [NUM_REQS-1:0]                 up_rsp_ready,

   output logic                                dn_req_valid,
   output logic                                dn_req_rw,
   output logic [DATA_WIDTH/8-1:0]             dn_req_byteen,
   output logic [ADDR_WIDTH-1:0]               dn_req_addr,
   output logic [DATA_WIDTH-1:0]               dn_req_data,
   output logic [TAG_WIDTH-1:0]                dn_req_tag,
   input  logic                                dn_req_ready,

   input  logic                                dn_rsp_valid,
   input  logic [DATA_WIDTH-1:0]               dn_rsp_data,
   input  logic [TAG_WIDTH-1:0]                dn_rsp_tag,
   output logic                                dn_rsp_ready
);

   localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam int BE_W  = DATA_WIDTH / 8;

   localparam logic ST_IDLE     = 1'b0;
   localparam logic ST_WAIT_RSP = 1'b1;

   generate
      if (NUM_REQS < 1 || NUM_REQS > 8) begin : g_bad_num_reqs
         $error("vx_ahb_mem_arbiter: NUM_REQS must be 1..8");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("vx_ahb_mem_arbiter: TIMEOUT_CYCLES must be >= 1");
      end
   endgenerate

   logic                 state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]     owner_q, owner_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;

   logic                 grant_vld;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     cand;
   logic                 sel_rw;
   logic [BE_W-1:0]      sel_byteen;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [TAG_WIDTH-1:0] sel_tag;
   logic                 rsp_fire;
   logic                 timed_out;

   // Scan downward so the candidate closest to rr_ptr is the last, winning, assignment.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
         cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQS);
         if (up_req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      sel_rw     = 1'b0;
      sel_byteen = '0;
      sel_addr   = '0;
      sel_data   = '0;
      sel_tag    = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (grant_idx == PTR_W'(i)) begin
            sel_rw     = up_req_rw[i];
            sel_byteen = up_req_byteen[i*BE_W +: BE_W];
            sel_addr   = up_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data   = up_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_tag    = up_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
         end
      end
   end

`ifdef VX_AHB_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wdog_q, wdog_d;

   assign timed_out = (state_q == ST_WAIT_RSP) && (wdog_q == WD_W'(TIMEOUT_CYCLES));

   // Saturates at the limit so the timeout response stays asserted until accepted.
   always_comb begin
      wdog_d = wdog_q;
      if (state_q != ST_WAIT_RSP || rsp_fire) begin
         wdog_d = '0;
      end else if (!dn_rsp_valid && !timed_out) begin
         wdog_d = wdog_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      owner_d        = owner_q;
      tag_d          = tag_q;
      rsp_fire       = 1'b0;
      up_req_ready   = '0;
      up_rsp_valid   = '0;
      up_rsp_data    = '0;
      up_rsp_tag     = '0;
      up_rsp_timeout = 1'b0;
      dn_req_valid   = 1'b0;
      dn_req_rw      = 1'b0;
      dn_req_byteen  = '0;
      dn_req_addr    = '0;
      dn_req_data    = '0;
      dn_req_tag     = '0;
      dn_rsp_ready   = 1'b0;

      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               // Nothing is outstanding, so any response seen here is stray and dropped.
               dn_rsp_ready = 1'b1;
               if (grant_vld) begin
                  dn_req_valid            = 1'b1;
                  dn_req_rw               = sel_rw;
                  dn_req_byteen           = sel_byteen;
                  dn_req_addr             = sel_addr;
                  dn_req_data             = sel_data;
                  dn_req_tag              = sel_tag;
                  up_req_ready[grant_idx] = dn_req_ready;
                  if (dn_req_ready) begin
                     state_d = ST_WAIT_RSP;
                     owner_d = grant_idx;
                     tag_d   = sel_tag;
                  end
               end
            end
            default: begin
               if (timed_out) begin
                  up_rsp_valid[owner_q] = 1'b1;
                  up_rsp_tag            = tag_q;
                  up_rsp_timeout        = 1'b1;
                  rsp_fire              = up_rsp_ready[owner_q];
               end else begin
                  up_rsp_valid[owner_q] = dn_rsp_valid;
                  dn_rsp_ready          = up_rsp_ready[owner_q];
                  if (dn_rsp_valid) begin
                     up_rsp_data = dn_rsp_data;
                     up_rsp_tag  = dn_rsp_tag;
                  end
                  rsp_fire = dn_rsp_valid && up_rsp_ready[owner_q];
               end
               if (rsp_fire) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = (owner_q == PTR_W'(NUM_REQS - 1)) ? '0 : owner_q + PTR_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         tag_q    <= tag_d;
      end
   end

endmodule

// File: tb/tb_vx_ahb_mem_arbiter.sv
// Directed bench for vx_ahb_mem_arbiter with NUM_REQS=2; the timeout scenario runs when VX_AHB_ARB_TIMEOUT_EN is defined.
module tb_vx_ahb_mem_arbiter;
   localparam int NR = 2;
   localparam int DW = 64;
   localparam int AW = 26;
   localparam int TW = 8;
   localparam int BW = DW / 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     up_req_valid, up_req_rw, up_req_ready;
   logic [NR*BW-1:0]  up_req_byteen;
   logic [NR*AW-1:0]  up_req_addr;
   logic [NR*DW-1:0]  up_req_data;
   logic [NR*TW-1:0]  up_req_tag;
   logic [NR-1:0]     up_rsp_valid, up_rsp_ready;
   logic [DW-1:0]     up_rsp_data;
   logic [TW-1:0]     up_rsp_tag;
   logic              up_rsp_timeout;
   logic              dn_req_valid, dn_req_rw, dn_req_ready;
   logic [BW-1:0]     dn_req_byteen;
   logic [AW-1:0]     dn_req_addr;
   logic [DW-1:0]     dn_req_data;
   logic [TW-1:0]     dn_req_tag;
   logic              dn_rsp_valid, dn_rsp_ready;
   logic [DW-1:0]     dn_rsp_data;
   logic [TW-1:0]     dn_rsp_tag;

   int checks = 0;
   int errors = 0;

   vx_ahb_mem_arbiter #(
      .NUM_REQS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset),
      .up_req_valid(up_req_valid), .up_req_rw(up_req_rw), .up_req_byteen(up_req_byteen),
      .up_req_addr(up_req_addr), .up_req_data(up_req_data), .up_req_tag(up_req_tag),
      .up_req_ready(up_req_ready),
      .up_rsp_valid(up_rsp_valid), .up_rsp_data(up_rsp_data), .up_rsp_tag(up_rsp_tag),
      .up_rsp_timeout(up_rsp_timeout), .up_rsp_ready(up_rsp_ready),
      .dn_req_valid(dn_req_valid), .dn_req_rw(dn_req_rw), .dn_req_byteen(dn_req_byteen),
      .dn_req_addr(dn_req_addr), .dn_req_data(dn_req_data), .dn_req_tag(dn_req_tag),
      .dn_req_ready(dn_req_ready),
      .dn_rsp_valid(dn_rsp_valid), .dn_rsp_data(dn_rsp_data), .dn_rsp_tag(dn_rsp_tag),
      .dn_rsp_ready(dn_rsp_ready)
   );

   always #5 clk = ~clk;

   // Requester 0: addr 0x10 tag 0x11, requester 1: addr 0x20 tag 0x22.
   task automatic set_default_reqs();
      up_req_rw     = 2'b10;
      up_req_byteen = {8'hF0, 8'h0F};
      up_req_addr   = {26'h20, 26'h10};
      up_req_data   = {64'h2222_0000_2222_0000, 64'h1111_0000_1111_0000};
      up_req_tag    = {8'h22, 8'h11};
   endtask

   task automatic test_reset();
      reset = 1'b1; up_req_valid = 2'b11; dn_req_ready = 1'b1;
      dn_rsp_valid = 1'b1; dn_rsp_data = '0; dn_rsp_tag = '0; up_rsp_ready = 2'b11;
      set_default_reqs();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (dn_req_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_req_valid got %b exp 0", dn_req_valid); end
      checks++; if (up_req_ready !== 2'b00) begin errors++; $display("FAIL reset_up_req_ready got %b exp 00", up_req_ready); end
      checks++; if (dn_rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_dn_rsp_ready got %b exp 0", dn_rsp_ready); end
      checks++; if (up_rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_up_rsp_valid got %b exp 00", up_rsp_valid); end
      dn_rsp_valid = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] exp_rdy;
      logic [AW-1:0] exp_addr;
      logic [TW-1:0] exp_tag;
      @(negedge clk);
      reset = 1'b0;
      for (int g = 0; g < 4; g++) begin
         exp_rdy  = (g % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (g % 2 == 0) ? 26'h10 : 26'h20;
         exp_tag  = (g % 2 == 0) ? 8'h11 : 8'h22;
         #1;
         checks++; if (up_req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", g, up_req_ready, exp_rdy); end
         checks++; if (dn_req_addr !== exp_addr) begin errors++; $display("FAIL rr_addr%0d got %h exp %h", g, dn_req_addr, exp_addr); end
         checks++; if (dn_req_tag !== exp_tag) begin errors++; $display("FAIL rr_tag%0d got %h exp %h", g, dn_req_tag, exp_tag); end
         @(negedge clk); #1;
         checks++; if ({dn_req_valid, up_req_ready} !== 3'b000) begin errors++; $display("FAIL rr_wait_block%0d got %b exp 000", g, {dn_req_valid, up_req_ready}); end
         dn_rsp_valid = 1'b1; dn_rsp_tag = exp_tag; dn_rsp_data = 64'(g);
         #1;
         checks++; if (up_rsp_valid !== exp_rdy) begin errors++; $display("FAIL rr_rsp_valid%0d got %b exp %b", g, up_rsp_valid, exp_rdy); end
         checks++; if (up_rsp_tag !== exp_tag) begin errors++; $display("FAIL rr_rsp_tag%0d got %h exp %h", g, up_rsp_tag, exp_tag); end
         @(negedge clk);
         dn_rsp_valid = 1'b0;
      end
   endtask

   task automatic test_single_req1();
      up_req_valid = 2'b10;
      up_req_addr  = {26'h100, 26'h10};
      up_req_tag   = {8'h5A, 8'h11};
      #1;
      checks++; if (dn_req_addr !== 26'h100) begin errors++; $display("FAIL req1_addr got %h exp 100", dn_req_addr); end
      checks++; if (up_req_ready !== 2'b10) begin errors++; $display("FAIL req1_ready got %b exp 10", up_req_ready); end
      @(negedge clk);
      up_req_valid = 2'b00;
      dn_rsp_valid = 1'b1; dn_rsp_tag = 8'h5A; dn_rsp_data = 64'h5A5A;
      #1;
      checks++; if (up_rsp_valid !== 2'b10) begin errors++; $display("FAIL req1_rsp_valid got %b exp 10", up_rsp_valid); end
      checks++; if (up_rsp_tag !== 8'h5A) begin errors++; $display("FAIL req1_rsp_tag got %h exp 5a", up_rsp_tag); end
      @(negedge clk);
      dn_rsp_valid = 1'b0;
      up_req_valid = 2'b11;
      #1;
      // rr_ptr wrapped back to 0 after owner 1 finished.
      checks++; if (up_req_ready !== 2'b01) begin errors++; $display("FAIL req1_ptr_wrap got %b exp 01", up_req_ready); end
      checks++; if (dn_req_addr !== 26'h10) begin errors++; $display("FAIL req1_ptr_addr got %h exp 10", dn_req_addr); end
   endtask

   task automatic test_rsp_backpressure();
      @(negedge clk);
      up_req_valid = 2'b00;
      up_rsp_ready = 2'b00;
      dn_rsp_valid = 1'b1; dn_rsp_tag = 8'h11; dn_rsp_data = 64'hDEAD_BEEF_CAFE_F00D;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (dn_rsp_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d dn_rsp_ready got %b exp 0", c, dn_rsp_ready); end
         checks++; if (up_rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_valid%0d got %b exp 01", c, up_rsp_valid); end
         @(negedge clk);
      end
      up_rsp_ready = 2'b01;
      #1;
      checks++; if (dn_rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake got %b exp 1", dn_rsp_ready); end
      checks++; if (up_rsp_data !== 64'hDEAD_BEEF_CAFE_F00D) begin errors++; $display("FAIL bp_data got %h exp deadbeefcafef00d", up_rsp_data); end
      checks++; if (up_rsp_timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", up_rsp_timeout); end
      @(negedge clk);
   endtask

   task automatic test_stray_rsp();
      up_rsp_ready = 2'b11;
      dn_rsp_valid = 1'b1; dn_rsp_data = 64'h1234; dn_rsp_tag = 8'h77;
      #1;
      checks++; if (dn_rsp_ready !== 1'b1) begin errors++; $display("FAIL stray_dn_rsp_ready got %b exp 1", dn_rsp_ready); end
      checks++; if (up_rsp_valid !== 2'b00) begin errors++; $display("FAIL stray_up_rsp_valid got %b exp 00", up_rsp_valid); end
      checks++; if (up_rsp_data !== 64'h0) begin errors++; $display("FAIL stray_data got %h exp 0", up_rsp_data); end
      @(negedge clk);
      dn_rsp_valid = 1'b0;
      up_req_valid = 2'b11;
      #1;
      // Still IDLE with rr_ptr=1 after owner 0 finished.
      checks++; if (up_req_ready !== 2'b10) begin errors++; $display("FAIL stray_no_state_change got %b exp 10", up_req_ready); end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      reset = 1'b1;
      dn_rsp_valid = 1'b1; dn_rsp_tag = 8'h22;
      #1;
      checks++; if (up_rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_rsp_valid got %b exp 00", up_rsp_valid); end
      @(negedge clk);
      reset = 1'b0;
      dn_rsp_valid = 1'b0;
      #1;
      checks++; if (dn_req_valid !== 1'b1) begin errors++; $display("FAIL midrst_idle got %b exp 1", dn_req_valid); end
      checks++; if (up_req_ready !== 2'b01) begin errors++; $display("FAIL midrst_grant0 got %b exp 01", up_req_ready); end
      checks++; if (dn_req_tag !== 8'h11) begin errors++; $display("FAIL midrst_tag got %h exp 11", dn_req_tag); end
      @(negedge clk);
      up_req_valid = 2'b00;
   endtask

`ifdef VX_AHB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      up_rsp_ready = 2'b00;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
      end
      #1;
      checks++; if (up_rsp_valid !== 2'b00) begin errors++; $display("FAIL to_early got %b exp 00", up_rsp_valid); end
      @(negedge clk); #1;
      checks++; if (up_rsp_valid !== 2'b01) begin errors++; $display("FAIL to_valid got %b exp 01", up_rsp_valid); end
      checks++; if (up_rsp_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", up_rsp_timeout); end
      checks++; if (up_rsp_data !== 64'h0) begin errors++; $display("FAIL to_data got %h exp 0", up_rsp_data); end
      checks++; if (up_rsp_tag !== 8'h11) begin errors++; $display("FAIL to_tag got %h exp 11", up_rsp_tag); end
      @(negedge clk); #1;
      checks++; if (up_rsp_timeout !== 1'b1) begin errors++; $display("FAIL to_hold got %b exp 1", up_rsp_timeout); end
      up_rsp_ready = 2'b01;
      @(negedge clk);
      dn_rsp_valid = 1'b1; dn_rsp_tag = 8'h11; dn_rsp_data = 64'hBAD;
      #1;
      checks++; if (dn_rsp_ready !== 1'b1) begin errors++; $display("FAIL to_late_ready got %b exp 1", dn_rsp_ready); end
      checks++; if (up_rsp_valid !== 2'b00) begin errors++; $display("FAIL to_late_valid got %b exp 00", up_rsp_valid); end
      @(negedge clk);
      dn_rsp_valid = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_single_req1();
      test_rsp_backpressure();
      test_stray_rsp();
      test_reset_mid_wait();
`ifdef VX_AHB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vx_ahb_mem_arbiter.md
VX_AHB_MEM_ARBITER -- requirements
Module: VX_ahb_mem_arbiter

Interface
REQ-001 Parameter NUM_REQS, default 2: number of Vortex memory requesters sharing one downstream AHB adapter port; legal range 1..8.
REQ-002 Parameter DATA_WIDTH, default 512: request and response data width.
REQ-003 Parameter ADDR_WIDTH, default 26: line address width.
REQ-004 Parameter TAG_WIDTH, default 56: request and response tag width.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024: response watchdog limit; used only when the REQ-027 macro is defined.
REQ-006 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Ports up_req_valid/up_req_rw, input, NUM_REQS each: per-requester request valid and write flag.
REQ-009 Ports up_req_byteen/addr/data/tag, input, NUM_REQS x (DATA_WIDTH/8, ADDR_WIDTH, DATA_WIDTH, TAG_WIDTH), flattened with requester i at slice i.
REQ-010 Port up_req_ready, output, NUM_REQS: per-requester request accept.
REQ-011 Ports up_rsp_valid, output, NUM_REQS; up_rsp_data, output, DATA_WIDTH; up_rsp_tag, output, TAG_WIDTH; up_rsp_timeout, output, 1: response to owner, broadcast data and tag.
REQ-012 Port up_rsp_ready, input, NUM_REQS: per-requester response accept.
REQ-013 Ports dn_req_valid/rw/byteen/addr/data/tag, output; dn_req_ready, input: request to the adapter, same widths.
REQ-014 Ports dn_rsp_valid/data/tag, input; dn_rsp_ready, output: response from the adapter.

Function
REQ-015 The arbiter SHALL run FSM states IDLE and WAIT_RSP, with one transaction outstanding at most.
REQ-016 In IDLE the arbiter SHALL select the first valid requester found searching from rr_ptr upward modulo NUM_REQS, and recompute the selection every cycle with no lock before handshake.
REQ-017 In IDLE with a winner, the arbiter SHALL drive the winner's fields onto dn_req_* combinationally (zero latency), with dn_req_valid=1 and up_req_ready[winner]=dn_req_ready.
REQ-018 On dn_req_valid&&dn_req_ready the arbiter SHALL latch owner=winner and the request tag, then enter WAIT_RSP.
REQ-019 In WAIT_RSP the arbiter SHALL hold all up_req_ready and dn_req_valid at 0.
REQ-020 In WAIT_RSP the arbiter SHALL set up_rsp_valid[owner]=dn_rsp_valid and pass dn_rsp_data/tag through, with dn_rsp_ready=up_rsp_ready[owner].
REQ-021 On the response handshake the arbiter SHALL return to IDLE and set rr_ptr=(owner+1) mod NUM_REQS.
REQ-022 In IDLE the arbiter SHALL drive dn_rsp_ready=1, silently discarding stray or late responses; all up_rsp_valid=0.
REQ-023 Non-owner up_rsp_valid bits SHALL always be 0, and up_rsp_data/tag SHALL be 0 when no up_rsp_valid is asserted.
REQ-024 With NUM_REQS=1 the arbiter SHALL degenerate to a single-outstanding pass-through with rr_ptr fixed at 0.

Reset
REQ-025 While reset=1 the arbiter SHALL force state=IDLE, rr_ptr=0, owner=0, latched tag=0 and watchdog=0; all valid/ready outputs SHALL be 0 that cycle.
REQ-026 Reset asserted mid-WAIT_RSP SHALL abandon the transaction, with no up_rsp_valid issued.

Configuration
REQ-027 With macro VX_AHB_ARB_TIMEOUT_EN defined: a watchdog SHALL count WAIT_RSP cycles without dn_rsp_valid. When it reaches TIMEOUT_CYCLES, the arbiter SHALL drive up_rsp_valid[owner]=1, up_rsp_data=0, up_rsp_tag=latched tag and up_rsp_timeout=1, hold these until up_rsp_ready[owner], then go to IDLE per REQ-021. The watchdog SHALL clear on leaving WAIT_RSP.
REQ-028 Without VX_AHB_ARB_TIMEOUT_EN: no watchdog logic; up_rsp_timeout SHALL be tied 0.

Verification
REQ-029 NUM_REQS=2, both valid from reset with dn_req_ready=1 -> grants in order 0,1,0,1 with one outstanding each; the req1 grant appears only after the req0 response handshake.
REQ-030 Only req1 valid, tag=0x5A, addr=0x100 -> dn_req_addr=0x100 the same cycle; dn_rsp tag 0x5A returns -> up_rsp_valid=2'b10; rr_ptr becomes 0.
REQ-031 Response with up_rsp_ready[owner]=0 for 3 cycles -> dn_rsp_ready=0 for those 3 cycles; the handshake occurs on cycle 4; data 0xDEAD... delivered intact.
REQ-032 dn_rsp_valid pulsed while in IDLE -> dn_rsp_ready=1, all up_rsp_valid=0, no state change.
REQ-033 Reset pulsed during WAIT_RSP -> next cycle IDLE, rr_ptr=0; the new request is granted to req0 first.
REQ-034 With VX_AHB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no dn_rsp -> up_rsp_valid[owner]=1 and up_rsp_timeout=1 after 16 WAIT_RSP cycles, data=0; a late dn_rsp is discarded in IDLE.
